// File: rtl/dvs_ravens_pkg.sv
// Shared DVS-to-Ravens types and sizing constants.
package dvs_ravens_pkg;

    localparam int EVENT_BITS               = 32;
    localparam int EVENT_QUEUE_DEPTH        = 64;
    localparam int EVENT_QUEUE_STARVE_LIMIT = 8;
    localparam int EQ_ADDR_BITS             = $clog2(EVENT_QUEUE_DEPTH);

    typedef logic [EVENT_BITS-1:0]   event_t;
    typedef logic [EQ_ADDR_BITS-1:0] eq_addr_t;

endpackage

// File: rtl/dummy_sram.sv
// Behavioural single-port SRAM with a registered read port (d_out valid the
// cycle after sense_en). Stands in for the event-queue macro.
module dummy_sram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] d_in,
    input  logic             wr_en,
    input  logic             sense_en,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] mem [DEPTH];

    // One access per cycle: write the array or register the addressed word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= d_in;
        if (sense_en) d_out <= mem[addr];
    end

endmodule

// File: rtl/event_queue_ctrl.sv
// Circular-FIFO controller for the single-port event-queue SRAM. Pushes from
// the capture front end have priority over fetches; a starvation counter
// forces one fetch after STARVE_LIMIT writes granted while a read was wanted.
// A one-entry output register hides the SRAM's registered read latency.
module event_queue_ctrl
    import dvs_ravens_pkg::*;
#(
    parameter int DEPTH        = EVENT_QUEUE_DEPTH,
    parameter int WIDTH        = EVENT_BITS,
    parameter int STARVE_LIMIT = EVENT_QUEUE_STARVE_LIMIT,
    localparam int AW          = $clog2(DEPTH),
    localparam int CW          = $clog2(DEPTH + 1),
    localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_event,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_event,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic [AW-1:0]    sram_addr,
    output logic [WIDTH-1:0] sram_d_in,
    output logic             sram_wr_en,
    output logic             sram_sense_en,
    input  logic [WIDTH-1:0] sram_d_out
);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [SW-1:0] starve;
    logic          rd_pending;
    logic          full, slot_free, want_rd, force_rd, push, fetch;

    // Port arbitration: push wins unless the starve limit forces a fetch.
    // Fetch is also gated by rst so the SRAM sees no access during reset.
    always_comb begin
        full          = (count == CW'(DEPTH));
        slot_free     = !rd_pending && (!out_valid || out_ready);
        want_rd       = (count != '0) && slot_free;
        force_rd      = want_rd && (starve == SW'(STARVE_LIMIT));
        in_ready      = !rst && !full && !force_rd;
        push          = in_valid && in_ready;
        fetch         = !rst && want_rd && !push;
        sram_wr_en    = push;
        sram_sense_en = fetch;
        sram_addr     = push ? wr_ptr : rd_ptr;
        sram_d_in     = in_event;
    end

    // Pointers, occupancy, starvation counter, output register and overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_pending <= 1'b0;
            out_valid  <= 1'b0;
            out_event  <= '0;
            starve     <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (fetch)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            // The slot is reusable as soon as the fetch is issued.
            count      <= count + CW'(push) - CW'(fetch);
            rd_pending <= fetch;

            if (fetch)
                starve <= '0;
            else if (push) begin
                if (want_rd && starve != SW'(STARVE_LIMIT))
                    starve <= starve + 1'b1;
            end else if (!want_rd)
                starve <= '0;

            // A returning word always lands, even over a same-cycle pop.
            if (rd_pending) begin
                out_event <= sram_d_out;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready)
                out_valid <= 1'b0;

            // The source cannot stall, so an offer while full is a lost event.
            if (in_valid && full)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_event_queue_ctrl.sv
// Directed bench for event_queue_ctrl with a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_event_queue_ctrl;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
    localparam int SL    = 3;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_event = '0;
    logic             out_ready = 1'b0;
    logic             in_ready, out_valid, overflow;
    logic [WIDTH-1:0] out_event, sram_d_in, sram_d_out;
    logic [CW-1:0]    count;
    logic [AW-1:0]    sram_addr;
    logic             sram_wr_en, sram_sense_en;

    always #5 clk = ~clk;

    event_queue_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_event(in_event), .in_ready(in_ready),
        .out_valid(out_valid), .out_event(out_event), .out_ready(out_ready),
        .count(count), .overflow(overflow),
        .sram_addr(sram_addr), .sram_d_in(sram_d_in),
        .sram_wr_en(sram_wr_en), .sram_sense_en(sram_sense_en),
        .sram_d_out(sram_d_out)
    );

    dummy_sram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_sram (
        .clk(clk), .addr(sram_addr), .d_in(sram_d_in),
        .wr_en(sram_wr_en), .sense_en(sram_sense_en), .d_out(sram_d_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of words stored in the SRAM, one in-flight read,
    // the visible output slot, and push/pop totals for address prediction.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ok = 0;
    bit               m_pend, m_ov, m_ovf;
    logic [WIDTH-1:0] m_inflight, m_oe;
    int               m_starve, m_npush, m_npop;

    bit               obs_ready, obs_wr, obs_sense;
    logic [WIDTH-1:0] popped[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = 0; m_ov = 0; m_ovf = 0; m_oe = '0; m_inflight = '0;
        m_starve = 0; m_npush = 0; m_npop = 0; m_ok = 1;
    endtask

    // Per-cycle compare, called mid-cycle with inputs stable.
    task automatic model_cycle();
        bit full, want, force_rd, exp_rdy, push, fetch;
        obs_ready = in_ready; obs_wr = sram_wr_en; obs_sense = sram_sense_en;
        if (!rst && out_valid && out_ready) popped.push_back(out_event);
        check("wr_sense_exclusive", {31'd0, sram_wr_en & sram_sense_en}, 32'd0);
        if (rst) begin
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check("rst_wr_en", {31'd0, sram_wr_en}, 32'd0);
            check("rst_sense_en", {31'd0, sram_sense_en}, 32'd0);
            model_reset();
            return;
        end
        if (!m_ok) return;
        full     = (m_q.size() == DEPTH);
        want     = (m_q.size() != 0) && !m_pend && (!m_ov || out_ready);
        force_rd = want && (m_starve == SL);
        exp_rdy  = !full && !force_rd;
        push     = in_valid && exp_rdy;
        fetch    = want && !push;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check("wr_en", {31'd0, sram_wr_en}, {31'd0, push});
        check("sense_en", {31'd0, sram_sense_en}, {31'd0, fetch});
        check("sram_addr", 32'(sram_addr), push ? 32'(m_npush % DEPTH) : 32'(m_npop % DEPTH));
        if (push) check("sram_d_in", 32'(sram_d_in), 32'(in_event));
        check("count", 32'(count), 32'(m_q.size()));
        check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (m_ov) check("out_event", 32'(out_event), 32'(m_oe));
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        // advance to the state after the coming edge
        if (in_valid && full) m_ovf = 1;
        if (m_pend) begin m_ov = 1; m_oe = m_inflight; end
        else if (m_ov && out_ready) m_ov = 0;
        m_pend = fetch;
        if (fetch) begin m_inflight = m_q.pop_front(); m_npop++; m_starve = 0; end
        if (push) begin
            m_q.push_back(in_event); m_npush++;
            if (want && m_starve < SL) m_starve++;
        end
        if (!push && !want) m_starve = 0;
    endtask

    task automatic step(input bit iv, input logic [WIDTH-1:0] ev, input bit ordy, input bit r);
        in_valid = iv; in_event = ev; out_ready = ordy; rst = r;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_retry(input logic [WIDTH-1:0] ev, input bit ordy);
        for (int i = 0; i < 8; i++) begin
            step(1, ev, ordy, 0);
            if (obs_ready) return;
        end
        check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (m_q.size() == 0 && !m_pend && !m_ov) begin
                step(0, '0, 1, 0);
                return;
            end
            step(0, '0, 1, 0);
        end
        check("drain_timeout", 32'd0, 32'd1);
    endtask

    bit exp_rdy_pat[6]   = '{1, 1, 1, 1, 0, 1};
    bit exp_sense_pat[6] = '{0, 0, 0, 0, 1, 0};

    initial begin
        // Reset
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        check("reset_count", 32'(count), 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);

        // Single event latency
        step(1, 16'h005A, 1, 0);
        check("t1_wr_at_t", {31'd0, obs_wr}, 32'd1);
        check("t1_count1", 32'(count), 32'd1);
        step(0, '0, 1, 0);
        check("t1_sense_at_t1", {31'd0, obs_sense}, 32'd1);
        check("t1_count0", 32'(count), 32'd0);
        step(0, '0, 0, 0);
        check("t1_out_valid", {31'd0, out_valid}, 32'd1);
        check("t1_out_event", 32'(out_event), 32'h5A);
        step(0, '0, 1, 0);
        check("t1_popped", {31'd0, out_valid}, 32'd0);

        // Fill to full with consumer stalled, then overflow
        popped.delete();
        for (int k = 1; k <= 5; k++) push_retry(WIDTH'(k), 0);
        step(1, 16'd6, 0, 0);
        check("full_in_ready", {31'd0, obs_ready}, 32'd0);
        check("full_count", 32'(count), 32'd4);
        check("full_overflow", {31'd0, overflow}, 32'd1);
        check("full_head", 32'(out_event), 32'd1);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        check("overflow_sticky", {31'd0, overflow}, 32'd1);
        drain();
        check("drain_n", 32'(popped.size()), 32'd5);
        for (int i = 0; i < 5 && i < popped.size(); i++)
            check("drain_order", 32'(popped[i]), 32'(i + 1));

        // Wrap-around: interleaved push/pop
        popped.delete();
        for (int k = 0; k < 10; k++) begin
            push_retry(WIDTH'(16'h100 + k), 0);
            for (int i = 0; i < 8 && popped.size() < k + 1; i++) step(0, '0, 1, 0);
            check("wrap_pop_seen", 32'(popped.size()), 32'(k + 1));
        end
        for (int i = 0; i < 10 && i < popped.size(); i++)
            check("wrap_order", 32'(popped[i]), 32'(16'h100 + i));
        drain();

        // Starvation limiter under continuous offers
        for (int i = 0; i < 6; i++) begin
            step(1, WIDTH'(16'h200 + i), 1, 0);
            check("starve_ready_pat", {31'd0, obs_ready}, {31'd0, exp_rdy_pat[i]});
            check("starve_sense_pat", {31'd0, obs_sense}, {31'd0, exp_sense_pat[i]});
        end
        for (int i = 6; i < 16; i++) step(1, WIDTH'(16'h200 + i), 1, 0);
        drain();

        // Consumer backpressure
        push_retry(16'hAAAA, 0);
        push_retry(16'hBBBB, 0);
        for (int i = 0; i < 6 && !out_valid; i++) step(0, '0, 0, 0);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 0, 0);
            check("bp_stable", 32'(out_event), 32'hAAAA);
            check("bp_no_fetch", {31'd0, obs_sense}, 32'd0);
        end
        step(0, '0, 1, 0);
        check("bp_release_fetch", {31'd0, obs_sense}, 32'd1);
        step(0, '0, 0, 0);
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_event", 32'(out_event), 32'hBBBB);
        drain();

        // Reset the cycle after a fetch
        push_retry(16'hCCCC, 0);
        step(0, '0, 0, 0);
        check("rst_mid_fetch", {31'd0, obs_sense}, 32'd1);
        check("rst_mid_ovf_before", {31'd0, overflow}, 32'd1);
        step(0, '0, 0, 1);
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_count", 32'(count), 32'd0);
        check("rst_mid_overflow", {31'd0, overflow}, 32'd0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        check("rst_mid_discard", {31'd0, out_valid}, 32'd0);
        check("rst_mid_count2", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
